vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Upstream raster/timing stage for the breakout display path. Runs on the 100 MHz board clock.
- Produces the pixel enable, hCount/vCount, bright, hSync/vSync for the VGA connector, and a once-per-N-frames game_tick.
- block_controller consumes hCount, vCount and bright for its fill decode.
- game_tick paces block_controller's object updates: paddle/ball motion advances once per tick.

Parameters:
- PIX_DIV, 4, clk cycles per pixel (100 MHz / 4 = 25 MHz); power of two, 2..8.
- H_TOTAL, 800, pixels per line.
- H_SYNC, 96, hSync low width; hSync low while hCount < H_SYNC.
- H_ACT_START, 144, first visible column.
- H_ACT_END, 783, last visible column.
- V_TOTAL, 525, lines per frame.
- V_SYNC, 2, vSync low width in lines.
- V_ACT_START, 35, first visible row.
- V_ACT_END, 514, last visible row.
- FRAME_DIV, 1, frames per game_tick, 1..15.
- SYNC_DLY, 1, extra pixel delay on syncs (used only with the optional feature).

Ports:
- clk, input, 1, 100 MHz system clock.
- rst, input, 1, reset; asynchronous, active-high.
- pix_en, output, 1, one-clk strobe every PIX_DIV clks.
- hCount, output, 10, column counter, 0..H_TOTAL-1.
- vCount, output, 10, line counter, 0..V_TOTAL-1.
- bright, output, 1, high inside the active window.
- hSync, output, 1, horizontal sync, active low.
- vSync, output, 1, vertical sync, active low.
- line_tick, output, 1, one-clk pulse on hCount wrap.
- frame_tick, output, 1, one-clk pulse on frame wrap.
- game_tick, output, 1, one-clk pulse every FRAME_DIV frames.

Behaviour:
- Reset is asynchronous, active-high; clock is clk. All state is reset.
- Reset values: pix_en=0, hCount=0, vCount=0, bright=0, hSync=0, vSync=0, all ticks=0. Divider count=0, frame count=0.
- Pixel divider: counts 0..PIX_DIV-1 on every clk. pix_en is registered and high for the single clk in which the divider equals PIX_DIV-1. First pix_en comes PIX_DIV clks after reset release.
- hCount advances only on clks where pix_en=1. At H_TOTAL-1 it wraps to 0, and vCount increments in the same clk.
- vCount wraps from V_TOTAL-1 to 0 when hCount also wraps.
- hSync, vSync and bright are registered and decoded from the next counter values. They therefore change in the same clk as hCount/vCount, with zero skew against the counters.
- bright = (H_ACT_START <= hCount <= H_ACT_END) && (V_ACT_START <= vCount <= V_ACT_END). Both bounds are inclusive.
- hSync=0 iff hCount < H_SYNC. vSync=0 iff vCount < V_SYNC.
- line_tick: high for one clk, coincident with the pix_en that moves hCount from H_TOTAL-1 to 0.
- frame_tick: high for one clk, coincident with the (H_TOTAL-1, V_TOTAL-1) -> (0,0) transition.
- game_tick: a 4-bit frame counter increments on each frame_tick. When it reaches FRAME_DIV-1, game_tick is asserted in the same clk as frame_tick and the counter clears. With FRAME_DIV=1, game_tick == frame_tick.
- game_tick falls during vertical blanking (vCount=0). Object state updated by the consumer is therefore stable for the whole visible frame.
- Counter arithmetic is 10-bit unsigned. Counters never reach values at or above H_TOTAL/V_TOTAL. There are no other states.
- Reset asserted mid-frame: all outputs return to reset values immediately and asynchronously. The counters restart at (0,0) after release. No tick is emitted during or at reset.

Optional Feature:
- Macro VGA_SYNC_DELAY_EN.
- Defined: hSync and vSync pass through an extra SYNC_DLY-stage shift register, advanced on pix_en. This aligns the syncs with a downstream registered rgb. Reset value of every stage is 0. hCount, vCount, bright and the ticks are unaffected.
- Undefined: syncs carry zero skew against the counters, as specified above.

Decomposition:
- Shared package vga_pkg holds the default timing constants (H_*, V_*) and the active-window bounds.
- block_controller imports the same active-window bounds from vga_pkg.
- One sub-module is natural: clk_en_div, a generic modulo-N strobe counter. It is used once for pix_en and once for the frame divider.

Test Plan:
- Reset release, 16 clks -> pix_en pulses at clks 4, 8, 12, 16; hCount reaches 4; hSync=0, bright=0.
- Run one line -> hSync rises when hCount=96; bright rises at hCount=144 and falls at hCount=784 (on vCount=35); line_tick once, after 3200 clks.
- Run to frame end -> after 800*525*4 = 1,680,000 clks, frame_tick is one clk wide at (799,524)->(0,0); vSync is low on lines 0-1 only.
- FRAME_DIV=3, run 6 frames -> exactly 2 game_ticks, on frame_ticks 3 and 6; each coincident with its frame_tick.
- Assert rst at hCount=500, vCount=200 for 3 clks -> all outputs 0 immediately; restart at (0,0); no spurious ticks.
- With VGA_SYNC_DELAY_EN defined and SYNC_DLY=1 -> hSync rises at hCount=97; bright edges are unchanged.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, active-window bounds and decode helpers
// used by the raster generator and by block_controller.
package vga_pkg;

    localparam int CNT_W       = 10;
    localparam int DIV_W       = 4;

    localparam int H_TOTAL     = 800;
    localparam int H_SYNC      = 96;
    localparam int H_ACT_START = 144;
    localparam int H_ACT_END   = 783;
    localparam int V_TOTAL     = 525;
    localparam int V_SYNC      = 2;
    localparam int V_ACT_START = 35;
    localparam int V_ACT_END   = 514;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic bright;
        logic hsync;
        logic vsync;
    } vid_ctl_t;

    // Inclusive range test; both window edges belong to the visible area.
    function automatic logic in_window(input cnt_t x, input cnt_t lo, input cnt_t hi);
        return (x >= lo) && (x <= hi);
    endfunction

endpackage

// File: rtl/clk_en_div.sv
// Generic modulo-N strobe counter: counts enabled clocks 0..N-1 and flags the
// enabled clock on which it wraps back to 0.
module clk_en_div
    import vga_pkg::*;
#(
    parameter int N = 4,
    parameter int W = DIV_W
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic hit
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count;

    assign hit = en && (count == LAST);

    // Modulo counter; clears on the wrapping clock, holds while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (hit) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel enable, h/v counters, bright, syncs and line/frame/game ticks.
// Optional macro VGA_SYNC_DELAY_EN delays hSync/vSync by SYNC_DLY pixels.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int PIX_DIV     = 4,
    parameter int H_TOTAL     = vga_pkg::H_TOTAL,
    parameter int H_SYNC      = vga_pkg::H_SYNC,
    parameter int H_ACT_START = vga_pkg::H_ACT_START,
    parameter int H_ACT_END   = vga_pkg::H_ACT_END,
    parameter int V_TOTAL     = vga_pkg::V_TOTAL,
    parameter int V_SYNC      = vga_pkg::V_SYNC,
    parameter int V_ACT_START = vga_pkg::V_ACT_START,
    parameter int V_ACT_END   = vga_pkg::V_ACT_END,
    parameter int FRAME_DIV   = 1
`ifdef VGA_SYNC_DELAY_EN
    ,
    parameter int SYNC_DLY    = 1
`endif
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pix_en,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             bright,
    output logic             hSync,
    output logic             vSync,
    output logic             line_tick,
    output logic             frame_tick,
    output logic             game_tick
);

    logic     pix_hit;
    logic     game_hit;
    logic     h_last;
    logic     v_last;
    logic     line_hit;
    logic     frame_hit;
    cnt_t     h_next;
    cnt_t     v_next;
    vid_ctl_t ctl_next;
    vid_ctl_t ctl;

    clk_en_div #(.N(PIX_DIV), .W(DIV_W)) u_pix_div (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .hit (pix_hit)
    );

    clk_en_div #(.N(FRAME_DIV), .W(DIV_W)) u_frame_div (
        .clk (clk),
        .rst (rst),
        .en  (frame_hit),
        .hit (game_hit)
    );

    // Next counter values; the control decode looks at these so it lands with the counters.
    always_comb begin
        h_last    = (hCount == cnt_t'(H_TOTAL - 1));
        v_last    = (vCount == cnt_t'(V_TOTAL - 1));
        line_hit  = pix_hit && h_last;
        frame_hit = line_hit && v_last;

        if (!pix_hit) begin
            h_next = hCount;
        end else if (h_last) begin
            h_next = '0;
        end else begin
            h_next = hCount + cnt_t'(1);
        end

        if (!line_hit) begin
            v_next = vCount;
        end else if (v_last) begin
            v_next = '0;
        end else begin
            v_next = vCount + cnt_t'(1);
        end

        ctl_next.bright = in_window(h_next, cnt_t'(H_ACT_START), cnt_t'(H_ACT_END))
                       && in_window(v_next, cnt_t'(V_ACT_START), cnt_t'(V_ACT_END));
        ctl_next.hsync  = (h_next >= cnt_t'(H_SYNC));
        ctl_next.vsync  = (v_next >= cnt_t'(V_SYNC));
    end

    // Raster state and strobes, all updated on the same edge as the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hCount     <= '0;
            vCount     <= '0;
            ctl        <= '0;
            pix_en     <= 1'b0;
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
            game_tick  <= 1'b0;
        end else begin
            hCount     <= h_next;
            vCount     <= v_next;
            ctl        <= ctl_next;
            pix_en     <= pix_hit;
            line_tick  <= line_hit;
            frame_tick <= frame_hit;
            game_tick  <= game_hit;
        end
    end

    assign bright = ctl.bright;

`ifdef VGA_SYNC_DELAY_EN
    logic [SYNC_DLY-1:0] hs_pipe;
    logic [SYNC_DLY-1:0] vs_pipe;

    // Pixel-rate sync delay line so syncs line up with a registered rgb downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_pipe <= '0;
            vs_pipe <= '0;
        end else if (pix_hit) begin
            for (int i = SYNC_DLY - 1; i > 0; i--) begin
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
            end
            hs_pipe[0] <= ctl.hsync;
            vs_pipe[0] <= ctl.vsync;
        end else begin
            hs_pipe <= hs_pipe;
            vs_pipe <= vs_pipe;
        end
    end

    assign hSync = hs_pipe[SYNC_DLY-1];
    assign vSync = vs_pipe[SYNC_DLY-1];
`else
    assign hSync = ctl.hsync;
    assign vSync = ctl.vsync;
`endif

endmodule
